// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage between the program ROM and the instruction decoder. Holds the
//   program counter, drives the ROM address, captures the combinationally
//   returned byte into a DEPTH-entry prefetch queue and presents {pc, byte}
//   pairs to the decoder over a valid/ready handshake. A branch redirect
//   flushes the queue and restarts fetch at the new address.
//
// Ports
//   clk            : clock, rising-edge
//   reset_n        : asynchronous active-low reset
//   rom_address    : ROM read address (registered, equals fetch_pc)
//   rom_data       : ROM byte at rom_address, same cycle
//   redirect_valid : branch/jump taken this cycle
//   redirect_pc    : new fetch address when redirect_valid=1
//   out_valid      : queue head holds a valid byte
//   out_data       : queue head byte
//   out_pc         : address the head byte was fetched from
//   out_ready      : decoder accepts the head this cycle
module instr_fetch_unit #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC0   = ADDR_W'(RESET_PC);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] queue;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               pop;
    logic               push;

    // A full queue can still accept a byte when the head leaves in the same
    // cycle, which is what keeps the stream gap-free under out_ready=1.
    // A redirect suppresses the push: the byte at the old fetch_pc is dead.
    assign pop  = out_valid & out_ready;
    assign push = ~redirect_valid & ((count != FULL) | pop);

    assign out_valid   = (count != '0);
    assign out_data    = queue[rd_ptr].data;
    assign out_pc      = queue[rd_ptr].pc;
    // Straight from the flop: no path from out_ready/redirect_valid.
    assign rom_address = fetch_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= PC0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            // Clearing storage makes out_data/out_pc read 0 out of reset.
            queue    <= '0;
        end else if (redirect_valid) begin
            // Any concurrent pop is simply absorbed: the head was accepted,
            // the rest of the queue is discarded along with it.
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                queue[wr_ptr] <= {fetch_pc, rom_data};
                wr_ptr        <= wr_ptr + PTR_W'(1);
                fetch_pc      <= fetch_pc + ADDR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit with a queue-based reference model and
//   a per-cycle compare process, plus hand-computed literal checks.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready = 1'b1;

    logic [DATA_W-1:0] rom [128];

    int n_chk  = 0;
    int n_fail = 0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rom_address    (rom_address),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    assign rom_data = rom[rom_address];

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue of {pc,data} in presentation order plus the next fetch address.
    logic [ADDR_W+DATA_W-1:0] mq[$];
    logic [ADDR_W-1:0]        mpc = '0;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            mq.delete();
            mpc = '0;
        end else begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (redirect_valid) begin
                mq.delete();
                mpc = redirect_pc;
            end else if (mq.size() < DEPTH) begin
                mq.push_back({mpc, rom[mpc]});
                mpc = mpc + 1'b1;
            end
        end
    end

    // Per-cycle compare against the model, mid-cycle.
    initial forever begin
        @(negedge clk);
        chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("m_rom_address", 32'(rom_address), 32'(mpc));
        if (mq.size() != 0) begin
            chk("m_out_pc", 32'(out_pc), 32'(mq[0][ADDR_W+DATA_W-1:DATA_W]));
            chk("m_out_data", 32'(out_data), 32'(mq[0][DATA_W-1:0]));
        end
    end

    // Log of pcs the decoder actually accepted (sampled before the edge).
    logic [ADDR_W-1:0] acc[$];
    initial forever begin
        @(negedge clk);
        if (reset_n && out_valid && out_ready) acc.push_back(out_pc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string name, input int pc, input int data);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_pc"}, 32'(out_pc), 32'(pc));
        chk({name, "_data"}, 32'(out_data), 32'(data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int s_pc [7];
        int s_dat[7];
        s_pc  = '{0, 1, 2, 3, 4, 5, 6};
        s_dat = '{'h86, 'hAA, 'h96, 'hF0, 'h20, 'hFE, 'h00};
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
        rom[0] = 8'h86; rom[1] = 8'hAA; rom[2] = 8'h96;
        rom[3] = 8'hF0; rom[4] = 8'h20; rom[5] = 8'hFE;
        rom[126] = 8'h5A; rom[127] = 8'hC3;

        // Reset stream
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rom_address", 32'(rom_address), 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            head("stream", s_pc[i], s_dat[i]);
        end

        // Backpressure
        reset_n = 1'b0; step(); reset_n = 1'b1;
        step();
        head("bp_first", 0, 'h86);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            head("bp_hold", 0, 'h86);
            chk("bp_rom_address", 32'(rom_address), 32'd2);
        end
        out_ready = 1'b1;
        step(); head("bp_rel1", 1, 'hAA);
        step(); head("bp_rel2", 2, 'h96);
        step(); head("bp_rel3", 3, 'hF0);

        // Redirect while queue holds pcs 1,2
        reset_n = 1'b0; step(); reset_n = 1'b1;
        acc.delete();
        step(); head("rd_h0", 0, 'h86);
        step(); head("rd_h1", 1, 'hAA);
        out_ready = 1'b0;
        step(); head("rd_full", 1, 'hAA);
        chk("rd_full_rom_address", 32'(rom_address), 32'd3);
        redirect_valid = 1'b1; redirect_pc = 7'd4;
        step();
        chk("rd_bubble", 32'(out_valid), 32'd0);
        chk("rd_rom_address", 32'(rom_address), 32'd4);
        redirect_valid = 1'b0; out_ready = 1'b1;
        step(); head("rd_h4", 4, 'h20);

        // Redirect with simultaneous pop, branch-to-self
        redirect_valid = 1'b1; redirect_pc = 7'd4;
        step();
        chk("self_bubble", 32'(out_valid), 32'd0);
        redirect_valid = 1'b0;
        step(); head("self_h4", 4, 'h20);
        step(); head("self_h5", 5, 'hFE);
        chk("acc_count", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            chk("acc0", 32'(acc[0]), 32'd0);
            chk("acc1", 32'(acc[1]), 32'd4);
            chk("acc2", 32'(acc[2]), 32'd4);
        end

        // Wrap-around
        redirect_valid = 1'b1; redirect_pc = 7'd126;
        step();
        chk("wrap_bubble", 32'(out_valid), 32'd0);
        chk("wrap_rom0", 32'(rom_address), 32'd126);
        redirect_valid = 1'b0;
        step(); head("wrap126", 126, 'h5A); chk("wrap_rom1", 32'(rom_address), 32'd127);
        step(); head("wrap127", 127, 'hC3); chk("wrap_rom2", 32'(rom_address), 32'd0);
        step(); head("wrap0", 0, 'h86);     chk("wrap_rom3", 32'(rom_address), 32'd1);
        step(); head("wrap1", 1, 'hAA);     chk("wrap_rom4", 32'(rom_address), 32'd2);

        // Reset mid-operation with the queue full
        out_ready = 1'b0;
        step(); step();
        head("mid_full", 1, 'hAA);
        chk("mid_full_rom_address", 32'(rom_address), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_rom_address", 32'(rom_address), 32'd0);
        step();
        reset_n = 1'b1; out_ready = 1'b1;
        step(); head("mid_h0", 0, 'h86);
        step(); head("mid_h1", 1, 'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
